// File: rtl/pattern_rx.sv
// Serial receiver for the out_fin pattern stream: recovers the DATA_BITS switch
// word from each start/data/stop frame, flags bad stop bits and counts good frames.
module pattern_rx #(
  parameter int BIT_TICKS   = 100,
  parameter int DATA_BITS   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 in_ser,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic [7:0]           frame_cnt
);

  localparam int CW = $clog2(BIT_TICKS);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF_M1  = CW'(BIT_TICKS / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(BIT_TICKS - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_armed;
  state_t                 r_state;
  logic [CW-1:0]          r_tick;
  logic [IW-1:0]          r_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_err;
  logic [7:0]             r_fcnt;

  logic                   w_s;
  logic                   w_sync_ok;
  logic                   w_armed_nxt;
  state_t                 w_state_nxt;
  logic [CW-1:0]          w_tick_nxt;
  logic [IW-1:0]          w_idx_nxt;
  logic [DATA_BITS-1:0]   w_shift_nxt;
  logic [DATA_BITS-1:0]   w_data_nxt;
  logic                   w_valid_nxt;
  logic                   w_err_nxt;
  logic [7:0]             w_fcnt_nxt;

  assign w_s       = r_sync[SYNC_STAGES-1];
  // r_fill marks when s reflects the real line rather than the reset value, so a
  // line already low at reset release is seen as a break, not a fresh start edge.
  assign w_sync_ok = r_fill[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      r_sync  <= '1;
      r_fill  <= '0;
      r_armed <= 1'b0;
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_fcnt  <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], in_ser};
      r_fill  <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_armed <= w_armed_nxt;
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    w_armed_nxt = r_armed;
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_err_nxt   = r_err;
    w_fcnt_nxt  = r_fcnt;
    case (r_state)
      S_IDLE: begin
        w_tick_nxt = '0;
        if (w_sync_ok) begin
          if (w_s)          w_armed_nxt = 1'b1;
          else if (r_armed) w_state_nxt = S_START;
          else              w_state_nxt = S_BREAK;
        end
      end
      S_START: begin
        if (r_tick == HALF_M1) begin
          w_tick_nxt  = '0;
          w_idx_nxt   = '0;
          w_state_nxt = w_s ? S_IDLE : S_DATA;
        end else begin
          w_tick_nxt = r_tick + CW'(1);
        end
      end
      S_DATA: begin
        if (r_tick == FULL_M1) begin
          w_tick_nxt         = '0;
          w_shift_nxt[r_idx] = w_s;
          if (r_idx == LAST_BIT) w_state_nxt = S_STOP;
          else                   w_idx_nxt   = r_idx + IW'(1);
        end else begin
          w_tick_nxt = r_tick + CW'(1);
        end
      end
      S_STOP: begin
        if (r_tick == FULL_M1) begin
          w_tick_nxt = '0;
          if (w_s) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
            w_err_nxt   = 1'b0;
            w_fcnt_nxt  = r_fcnt + 8'd1;
            w_state_nxt = S_IDLE;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_tick_nxt = r_tick + CW'(1);
        end
      end
      S_BREAK: begin
        w_tick_nxt = '0;
        if (w_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign data_out  = r_data;
  assign valid     = r_valid;
  assign frame_err = r_err;
  assign frame_cnt = r_fcnt;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_pattern_rx.sv
// Directed bench for pattern_rx with BIT_TICKS=8: good frames, back-to-back,
// bad stop/break, idle glitch, mid-frame reset and frame counter wrap.
module tb_pattern_rx;

  localparam int BT = 8;
  localparam int FRAME_CYC = 6 * BT;
  localparam int LAT = 2 + BT / 2 + 5 * BT + 1;  // drive-to-valid: sync + T0+45

  logic       sysclk = 1'b0;
  logic       reset  = 1'b0;
  logic       in_ser = 1'b1;
  logic [3:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;
  logic [7:0] frame_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int vcount   = 0;
  int last_vcyc = 0;
  int prev_vcyc = 0;
  logic prev_valid = 1'b0;
  logic dbl_pulse  = 1'b0;

  pattern_rx #(.BIT_TICKS(BT), .DATA_BITS(4), .SYNC_STAGES(2)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .in_ser    (in_ser),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc++;

  always @(negedge sysclk) begin
    if (valid) begin
      vcount++;
      prev_vcyc = last_vcyc;
      last_vcyc = cyc;
      if (prev_valid) dbl_pulse = 1'b1;
    end
    prev_valid = valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic send_frame(input logic [3:0] d, input logic stop);
    in_ser = 1'b0;
    wait_cyc(BT);
    for (int i = 0; i < 4; i++) begin
      in_ser = d[i];
      wait_cyc(BT);
    end
    in_ser = stop;
    wait_cyc(BT);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(5);
  endtask

  int t0;
  int v0;

  initial begin
    // Reset with the line low: must be ignored.
    wait_cyc(2);
    in_ser = 1'b0;
    wait_cyc(3);
    check("rst_data",  data_out,  0);
    check("rst_valid", valid,     0);
    check("rst_err",   frame_err, 0);
    check("rst_busy",  busy,      0);
    check("rst_cnt",   frame_cnt, 0);
    in_ser = 1'b1;
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(5);
    check("idle_busy", busy, 0);

    // Single good frame 1010 and exact latency.
    t0 = cyc;
    send_frame(4'b1010, 1'b1);
    wait_cyc(2);
    check("f1_vcount", vcount, 1);
    check("f1_latency", last_vcyc - t0, LAT);
    check("f1_data", data_out, 4'b1010);
    check("f1_err",  frame_err, 0);
    check("f1_cnt",  frame_cnt, 1);

    // Back-to-back frames, zero idle gap.
    v0 = vcount;
    send_frame(4'b0001, 1'b1);
    send_frame(4'b1111, 1'b1);
    wait_cyc(3);
    check("b2b_vcount", vcount - v0, 2);
    check("b2b_spacing", last_vcyc - prev_vcyc, FRAME_CYC);
    check("b2b_data", data_out, 4'b1111);
    check("b2b_cnt",  frame_cnt, 3);

    // Bad stop bit, line low 20 cycles from stop bit start.
    v0 = vcount;
    send_frame(4'b0110, 1'b0);
    wait_cyc(12);
    check("brk_err",  frame_err, 1);
    check("brk_busy", busy, 1);
    check("brk_data", data_out, 4'b1111);
    check("brk_cnt",  frame_cnt, 3);
    check("brk_novalid", vcount - v0, 0);
    in_ser = 1'b1;
    wait_cyc(5);
    check("brk_release_busy", busy, 0);
    send_frame(4'b0011, 1'b1);
    wait_cyc(2);
    check("rec_err",  frame_err, 0);
    check("rec_data", data_out, 4'b0011);
    check("rec_cnt",  frame_cnt, 4);

    // Two-cycle glitch on the idle line.
    v0 = vcount;
    in_ser = 1'b0;
    wait_cyc(2);
    in_ser = 1'b1;
    wait_cyc(2);
    check("gl_busy_start", busy, 1);
    wait_cyc(10);
    check("gl_busy_end", busy, 0);
    check("gl_novalid", vcount - v0, 0);
    check("gl_err", frame_err, 0);
    check("gl_cnt", frame_cnt, 4);

    // Reset during data bit 2 of a frame.
    v0 = vcount;
    in_ser = 1'b0; wait_cyc(BT);
    in_ser = 1'b1; wait_cyc(BT);
    in_ser = 1'b0; wait_cyc(BT);
    in_ser = 1'b0; wait_cyc(BT / 2);
    reset  = 1'b0;
    in_ser = 1'b1;
    wait_cyc(4);
    check("mr_data",  data_out, 0);
    check("mr_valid", valid, 0);
    check("mr_err",   frame_err, 0);
    check("mr_busy",  busy, 0);
    check("mr_cnt",   frame_cnt, 0);
    reset = 1'b1;
    wait_cyc(5);
    send_frame(4'b1001, 1'b1);
    wait_cyc(2);
    check("mr_vcount", vcount - v0, 1);
    check("mr_new_data", data_out, 4'b1001);
    check("mr_new_cnt",  frame_cnt, 1);

    // 256 good frames: counter wraps back to 0.
    pulse_reset();
    v0 = vcount;
    for (int i = 0; i < 255; i++) send_frame(4'b0101, 1'b1);
    wait_cyc(2);
    check("wrap_cnt_255", frame_cnt, 255);
    send_frame(4'b0101, 1'b1);
    wait_cyc(2);
    check("wrap_cnt_0",  frame_cnt, 0);
    check("wrap_vcount", vcount - v0, 256);
    check("wrap_data",   data_out, 4'b0101);
    check("wrap_err",    frame_err, 0);

    check("single_cycle_valid", dbl_pulse, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
